// File: rtl/sampler_pkg.sv
// Shared definitions for the sample voice sequencer: the frame FSM states,
// default sample geometry, and the saturating clip used by the mixer.
package sampler_pkg;

    localparam int DEF_SAMPLE_W    = 16;
    localparam int DEF_VOICE_DEPTH = 8192;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        LAST,
        OUT
    } seq_state_e;

    // Clamp a sign-extended value into the signed range of a w-bit sample.
    // The caller truncates the result to w bits.
    function automatic logic signed [31:0] sat_clip(input logic signed [31:0] v,
                                                    input int unsigned w);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (w - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (w - 1));
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end else begin
            return v;
        end
    endfunction

endpackage

// File: rtl/sample_mix_sat.sv
// Frame accumulator for the voice sequencer. Sums the signed ROM samples of
// the active voices over one frame and presents the running sum, including
// the sample arriving this cycle, clipped to the output sample width.
module sample_mix_sat
    import sampler_pkg::*;
#(
    parameter int SAMPLE_W = DEF_SAMPLE_W,
    parameter int ACC_W    = DEF_SAMPLE_W + 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clear_i,
    input  logic                add_en_i,
    input  logic [SAMPLE_W-1:0] data_i,
    output logic [SAMPLE_W-1:0] clip_o
);

    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] acc_d;
    logic signed [ACC_W-1:0] addend;
    logic signed [ACC_W-1:0] acc_sum;

    // Sign-extend the incoming sample, add it only for a real read, and clip.
    always_comb begin
        addend  = add_en_i ? ACC_W'($signed(data_i)) : '0;
        acc_sum = acc_q + addend;
        acc_d   = clear_i ? '0 : acc_sum;
        clip_o  = SAMPLE_W'(sat_clip(32'(acc_sum), SAMPLE_W));
    end

    // Accumulator register; cleared at the start of every frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/sample_voice_sequencer.sv
// One-shot sample voice sequencer sharing a single synchronous ROM port.
// Each audio tick starts a frame that reads one sample per voice, mixes the
// results with saturation and emits one output sample.
// Build option: define SAMPLE_EXCLUSIVE_EN for monophonic playback, where the
// lowest-index triggered voice takes over and every other voice is silenced.
module sample_voice_sequencer
    import sampler_pkg::*;
#(
    parameter int NUM_VOICES  = 2,
    parameter int SAMPLE_W    = DEF_SAMPLE_W,
    parameter int VOICE_DEPTH = DEF_VOICE_DEPTH,
    parameter int ADDR_W      = $clog2(NUM_VOICES * VOICE_DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  audio_tick,
    input  logic [NUM_VOICES-1:0] trig,
    input  logic                  stop_all,
    output logic [ADDR_W-1:0]     rom_addr,
    output logic                  rom_rd,
    input  logic [SAMPLE_W-1:0]   rom_data,
    output logic [SAMPLE_W-1:0]   sample_out,
    output logic                  sample_valid,
    output logic [NUM_VOICES-1:0] voice_active,
    output logic                  busy
);

    localparam int PTR_W = $clog2(VOICE_DEPTH);
    localparam int KW    = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam int ACC_W = SAMPLE_W + $clog2(NUM_VOICES);

    seq_state_e             state_q, state_d;
    logic [KW-1:0]          k_q, k_d;
    logic [NUM_VOICES-1:0]  active_q, active_d;
    logic [NUM_VOICES-1:0]  pending_q, pending_d;
    logic                   pend_stop_q, pend_stop_d;
    logic [PTR_W-1:0]       ptr_q [NUM_VOICES];
    logic [PTR_W-1:0]       ptr_d [NUM_VOICES];
    logic                   rd_prev_q;
    logic [SAMPLE_W-1:0]    sample_q;
    logic                   valid_q;

    logic                   acc_clear;
    logic                   load_out;
    logic                   rd_now;
    logic [ADDR_W-1:0]      addr_now;
    logic [31:0]            addr_full;
    logic [NUM_VOICES-1:0]  start_mask;
    logic [SAMPLE_W-1:0]    mix_clip;
`ifdef SAMPLE_EXCLUSIVE_EN
    logic [NUM_VOICES-1:0]  sel_mask;
    logic                   sel_found;
`endif

    // Frame sequencing: tick acceptance, one ROM read per voice, then output.
    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        active_d    = active_q;
        pending_d   = pending_q | trig;
        pend_stop_d = pend_stop_q | stop_all;
        for (int i = 0; i < NUM_VOICES; i++) begin
            ptr_d[i] = ptr_q[i];
        end
        acc_clear   = 1'b0;
        load_out    = 1'b0;
        rd_now      = 1'b0;
        addr_now    = '0;
        addr_full   = '0;
        start_mask  = pending_q | trig;
`ifdef SAMPLE_EXCLUSIVE_EN
        sel_mask    = '0;
        sel_found   = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                if (audio_tick) begin
                    state_d     = READ;
                    k_d         = '0;
                    acc_clear   = 1'b1;
                    pending_d   = '0;
                    pend_stop_d = 1'b0;
                    if (pend_stop_q || stop_all) begin
                        active_d = '0;
                    end else begin
`ifdef SAMPLE_EXCLUSIVE_EN
                        for (int i = 0; i < NUM_VOICES; i++) begin
                            if (start_mask[i] && !sel_found) begin
                                sel_found   = 1'b1;
                                sel_mask[i] = 1'b1;
                                ptr_d[i]    = '0;
                            end
                        end
                        if (sel_found) begin
                            active_d = sel_mask;
                        end
`else
                        for (int i = 0; i < NUM_VOICES; i++) begin
                            if (start_mask[i]) begin
                                active_d[i] = 1'b1;
                                ptr_d[i]    = '0;
                            end
                        end
`endif
                    end
                end
            end
            READ: begin
                rd_now    = active_q[k_q];
                addr_full = (32'(k_q) << PTR_W) | 32'(ptr_q[k_q]);
                addr_now  = addr_full[ADDR_W-1:0];
                if (rd_now) begin
                    if (ptr_q[k_q] == PTR_W'(VOICE_DEPTH - 1)) begin
                        active_d[k_q] = 1'b0;
                        ptr_d[k_q]    = '0;
                    end else begin
                        ptr_d[k_q] = ptr_q[k_q] + PTR_W'(1);
                    end
                end
                if (k_q == KW'(NUM_VOICES - 1)) begin
                    state_d = LAST;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            LAST: begin
                load_out = 1'b1;
                state_d  = OUT;
            end
            OUT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, voice bookkeeping and output sample registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            k_q         <= '0;
            active_q    <= '0;
            pending_q   <= '0;
            pend_stop_q <= 1'b0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                ptr_q[i] <= '0;
            end
            rd_prev_q   <= 1'b0;
            sample_q    <= '0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            active_q    <= active_d;
            pending_q   <= pending_d;
            pend_stop_q <= pend_stop_d;
            for (int i = 0; i < NUM_VOICES; i++) begin
                ptr_q[i] <= ptr_d[i];
            end
            rd_prev_q   <= rd_now;
            valid_q     <= load_out;
            if (load_out) begin
                sample_q <= mix_clip;
            end
        end
    end

    sample_mix_sat #(
        .SAMPLE_W (SAMPLE_W),
        .ACC_W    (ACC_W)
    ) u_mix (
        .clk      (clk),
        .reset    (reset),
        .clear_i  (acc_clear),
        .add_en_i (rd_prev_q),
        .data_i   (rom_data),
        .clip_o   (mix_clip)
    );

    assign rom_addr     = addr_now;
    assign rom_rd       = rd_now;
    assign sample_out   = sample_q;
    assign sample_valid = valid_q;
    assign voice_active = active_q;
    assign busy         = (state_q != IDLE);

endmodule
